// File: rtl/vga_timing_pkg.sv
// Raster timing constants and helpers shared by the timing generator.
// Defaults describe the standard 640x480@60 mode.
package vga_timing_pkg;

    localparam int DEF_CW       = 10;
    localparam int DEF_FW       = 8;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Total period of one axis: visible + porches + sync.
    function automatic int span_total(
        input int act,
        input int fp,
        input int sync,
        input int bp
    );
        return act + fp + sync + bp;
    endfunction

    // True when a counter of width cw can hold 0..total-1.
    function automatic bit fits_cw(input int total, input int cw);
        if (cw <= 0 || cw > 30)
            return 1'b0;
        return (total > 0) && (total <= (1 << cw));
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Counter that counts 0..LIMIT and wraps to 0.
// clr has priority over en; at_limit flags the terminal value.
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int W     = DEF_CW,
    parameter int LIMIT = DEF_H_TOTAL - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    assign at_limit = (count == LIM);

    // Clear, else step with wrap at LIMIT, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= at_limit ? '0 : count + W'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v wrap counters plus
// registered sync, blanking and line/frame markers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FW       = DEF_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          restart,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_end,
    output logic          frame_end,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // One extra bit so that bounds equal to 2^CW stay representable.
    localparam logic [CW:0] HA    = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] VA    = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_LO = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_HI = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] VS_LO = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_HI = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    if (!fits_cw(H_TOTAL, CW) || !fits_cw(V_TOTAL, CW) ||
        H_SYNC == 0 || V_SYNC == 0) begin : g_cfg_err
        $error("vga_timing_gen: bad raster configuration");
    end

    logic          h_last;
    logic          v_last;
    logic          v_en;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;
    logic          le_nxt;
    logic          fe_nxt;
    logic          frame_wrap;

    assign v_en = enable & h_last;

    wrap_counter #(
        .W     (CW),
        .LIMIT (H_TOTAL - 1)
    ) u_h (
        .clk      (clk),
        .rst      (rst),
        .en       (enable),
        .clr      (restart),
        .count    (h_count),
        .at_limit (h_last)
    );

    wrap_counter #(
        .W     (CW),
        .LIMIT (V_TOTAL - 1)
    ) u_v (
        .clk      (clk),
        .rst      (rst),
        .en       (v_en),
        .clr      (restart),
        .count    (v_count),
        .at_limit (v_last)
    );

    // Position the counters will hold after this edge, so the
    // registered flags line up with the counts with zero skew.
    always_comb begin
        h_nxt = h_count;
        v_nxt = v_count;
        if (restart) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (enable) begin
            h_nxt = h_last ? '0 : h_count + CW'(1);
            if (h_last)
                v_nxt = v_last ? '0 : v_count + CW'(1);
        end
    end

    // Decode the upcoming position into sync/blank/marker levels.
    always_comb begin
        h_ext      = {1'b0, h_nxt};
        v_ext      = {1'b0, v_nxt};
        hs_nxt     = (h_ext >= HS_LO) && (h_ext < HS_HI);
        vs_nxt     = (v_ext >= VS_LO) && (v_ext < VS_HI);
        act_nxt    = (h_ext < HA) && (v_ext < VA);
        le_nxt     = (h_nxt == H_LAST);
        fe_nxt     = le_nxt && (v_nxt == V_LAST);
        frame_wrap = !restart && enable && h_last && v_last;
    end

    // Registered flags and the completed-frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b1;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            frame_count <= '0;
        end else begin
            hsync     <= hs_nxt ? HS_POL : ~HS_POL;
            vsync     <= vs_nxt ? VS_POL : ~VS_POL;
            active    <= act_nxt;
            line_end  <= le_nxt;
            frame_end <= fe_nxt;
            if (frame_wrap)
                frame_count <= frame_count + FW'(1);
        end
    end

endmodule
